dram_read_master: RTL and testbench

- Responder end of the pixel-domain DRAM read request interface: accepts single-cycle read requests (address, beat count) from the image sender and turns them into AXI4 read bursts on the DDR port.
- Returns beats to the requester as a data/valid stream and holds the requester off with a busy flag.
- Splits any request that crosses a 4 KB boundary into compliant bursts and records protocol errors in sticky flags.

---
 rtl/dram_read_master.sv | 175 +++++++++++++++++
 tb/tb_dram_read_master.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_master.sv
// ----------------------------------------------------------------------------
// dram_read_master
//
// Purpose:
//   Takes single-cycle read requests (byte address + beat count) from the
//   pixel-domain image sender and turns them into AXI4 INCR read bursts.
//   A request that would cross a 4 KB page is split into several bursts.
//   Only one burst is outstanding at a time. Returned beats are forwarded
//   one cycle after their R handshake as a data/valid stream. Protocol
//   problems are recorded in sticky error flags.
//
// Ports:
//   clk_pixel, dram_reader_resetn   clock and asynchronous active-low reset
//   dram_read_addr/len/en           request: byte address, beats-1, strobe
//   dram_read_busy                  request in progress (registered)
//   dram_read_data/_valid           returned beat and its one-cycle qualifier
//   m_axi_ar*                       AXI read address channel
//   m_axi_r*                        AXI read data channel
//   read_error                      sticky: [0] bad RRESP, [1] RLAST mismatch,
//                                   [2] request dropped while busy
//   error_clear                     synchronous clear of read_error
// ----------------------------------------------------------------------------
module dram_read_master #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_resetn,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [2:0]                 read_error,
  input  logic                       error_clear
);

  localparam int BPB = DRAM_DATA_WIDTH / 8;
  localparam int LSB = $clog2(BPB);
  localparam logic [DRAM_ADDR_WIDTH-1:0] ALIGN_MASK = ~DRAM_ADDR_WIDTH'(BPB - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                     state;
  logic [DRAM_ADDR_WIDTH-1:0] cur_addr;
  logic [8:0]                 remaining;
  logic [8:0]                 beat_cnt;

  logic [DRAM_ADDR_WIDTH-1:0] req_addr;
  logic [8:0]                 req_beats;
  logic [8:0]                 first_beats;
  logic [8:0]                 next_beats;
  logic [8:0]                 issued_beats;
  logic                       beat_fire;
  logic                       drop_req;
  logic [2:0]                 err_set;

  // Beats that fit in a burst: the smaller of what is left and what remains
  // of the current 4 KB page. A page-aligned address gives the full page.
  function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                             input logic [8:0]  left);
    logic [12:0] room_bytes;
    logic [12:0] room;
    room_bytes = 13'd4096 - {1'b0, page_off};
    room       = room_bytes >> LSB;
    if ({4'b0, left} < room) return left;
    else                     return 9'(room);
  endfunction

  assign m_axi_arsize  = 3'(LSB);
  assign m_axi_arburst = 2'b01;

  assign req_addr     = dram_read_addr & ALIGN_MASK;
  assign req_beats    = {1'b0, dram_read_len} + 9'd1;
  assign first_beats  = burst_beats(req_addr[11:0], req_beats);
  assign next_beats   = burst_beats(cur_addr[11:0], remaining);
  assign issued_beats = {1'b0, m_axi_arlen} + 9'd1;
  assign beat_fire    = m_axi_rvalid && m_axi_rready;
  assign drop_req     = dram_read_en && (state != IDLE);

  // The beat counter, not RLAST, decides where a burst ends; RLAST is only
  // checked against it.
  assign err_set = {drop_req,
                    beat_fire && (m_axi_rlast != (beat_cnt == 9'd1)),
                    beat_fire && (m_axi_rresp != 2'b00)};

  // Request sequencer. Every AXI and requester-facing output is registered
  // here; araddr/arlen/arvalid are only written when entering ADDR so they
  // stay stable until the handshake.
  always_ff @(posedge clk_pixel or negedge dram_reader_resetn) begin
    if (!dram_reader_resetn) begin
      state                <= IDLE;
      cur_addr             <= '0;
      remaining            <= '0;
      beat_cnt             <= '0;
      dram_read_busy       <= 1'b0;
      dram_read_data       <= '0;
      dram_read_data_valid <= 1'b0;
      m_axi_araddr         <= '0;
      m_axi_arlen          <= '0;
      m_axi_arvalid        <= 1'b0;
      m_axi_rready         <= 1'b0;
    end else begin
      dram_read_data_valid <= beat_fire;
      if (beat_fire) dram_read_data <= m_axi_rdata;

      case (state)
        IDLE: begin
          if (dram_read_en) begin
            cur_addr       <= req_addr;
            remaining      <= req_beats;
            m_axi_araddr   <= req_addr;
            m_axi_arlen    <= 8'(first_beats - 9'd1);
            m_axi_arvalid  <= 1'b1;
            dram_read_busy <= 1'b1;
            state          <= ADDR;
          end
        end

        ADDR: begin
          if (m_axi_arvalid && m_axi_arready) begin
            cur_addr      <= cur_addr + (DRAM_ADDR_WIDTH'(issued_beats) << LSB);
            remaining     <= remaining - issued_beats;
            beat_cnt      <= issued_beats;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= DATA;
          end
        end

        DATA: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt - 9'd1;
            if (beat_cnt == 9'd1) begin
              m_axi_rready <= 1'b0;
              if (remaining != 9'd0) begin
                m_axi_araddr  <= cur_addr;
                m_axi_arlen   <= 8'(next_beats - 9'd1);
                m_axi_arvalid <= 1'b1;
                state         <= ADDR;
              end else begin
                dram_read_busy <= 1'b0;
                state          <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as error_clear wins.
  always_ff @(posedge clk_pixel or negedge dram_reader_resetn) begin
    if (!dram_reader_resetn) begin
      read_error <= 3'b000;
    end else begin
      read_error <= (error_clear ? 3'b000 : read_error) | err_set;
    end
  end

endmodule

// File: tb/tb_dram_read_master.sv
// ----------------------------------------------------------------------------
// tb_dram_read_master
//
// Purpose:
//   Self-checking bench for dram_read_master. A behavioural AXI slave answers
//   AR requests (with optional arready stall and error injection) and returns
//   beats whose data encodes the beat address. Expected beats are queued when
//   a request is issued and compared when dram_read_data_valid appears.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_dram_read_master;

  localparam int AW = 39;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] read_addr;
  logic [7:0]    read_len;
  logic          read_en;
  logic          busy;
  logic [DW-1:0] data;
  logic          data_valid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [2:0]    read_error;
  logic          error_clear;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] data_q[$];
  logic [AW-1:0] ar_addr_log[$];
  logic [7:0]    ar_len_log[$];
  int            ar_hs_before[$];

  int ar_stall        = 0;
  int err_resp_beat   = -1;
  int early_last_beat = -1;
  int r_hs_total      = 0;
  int beats_seen      = 0;
  int ar_held_cycles  = 0;
  int ar_hold_bad     = 0;

  always #5 clk = ~clk;

  dram_read_master #(
    .DRAM_ADDR_WIDTH(AW),
    .DRAM_DATA_WIDTH(DW)
  ) dut (
    .clk_pixel           (clk),
    .dram_reader_resetn  (resetn),
    .dram_read_addr      (read_addr),
    .dram_read_len       (read_len),
    .dram_read_en        (read_en),
    .dram_read_busy      (busy),
    .dram_read_data      (data),
    .dram_read_data_valid(data_valid),
    .m_axi_araddr        (araddr),
    .m_axi_arlen         (arlen),
    .m_axi_arsize        (arsize),
    .m_axi_arburst       (arburst),
    .m_axi_arvalid       (arvalid),
    .m_axi_arready       (arready),
    .m_axi_rdata         (rdata),
    .m_axi_rresp         (rresp),
    .m_axi_rlast         (rlast),
    .m_axi_rvalid        (rvalid),
    .m_axi_rready        (rready),
    .read_error          (read_error),
    .error_clear         (error_clear)
  );

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {25'h1A5A5A5, a, 25'h00ACE, a};
  endfunction

  // AXI slave and output monitor. Works on the falling edge: DUT outputs seen
  // here are what the next rising edge will sample.
  initial begin : axi_slave
    int            beats_left;
    int            beat_idx;
    int            burst_len;
    int            stall_cnt;
    logic [AW-1:0] beat_addr;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_len;
    logic          hold_valid;
    logic          rready_prev;
    logic          hs_now;
    logic [DW-1:0] exp_data;
    beats_left = 0; beat_idx = 0; burst_len = 0; stall_cnt = 0;
    beat_addr = '0; hold_addr = '0; hold_len = '0; hold_valid = 1'b0;
    rready_prev = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        beats_left = 0; stall_cnt = 0; hold_valid = 1'b0; rready_prev = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else begin
        hs_now = rvalid && rready_prev;
        checks++;
        if (data_valid !== hs_now) begin
          errors++;
          $display("[TB] FAIL valid_latency: data_valid=%0b expected %0b at %0t", data_valid, hs_now, $time);
        end
        if (data_valid === 1'b1) begin
          beats_seen++;
          checks++;
          if (data_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_beat: data=%h with no beat expected at %0t", data, $time);
          end else begin
            exp_data = data_q.pop_front();
            if (data !== exp_data) begin
              errors++;
              $display("[TB] FAIL beat_data: got %h expected %h at %0t", data, exp_data, $time);
            end
          end
        end
        if (hs_now) begin
          r_hs_total++;
          beats_left--;
          beat_idx++;
          beat_addr = beat_addr + AW'(16);
        end
        if (arready) begin
          arready    = 1'b0;
          beats_left = burst_len;
          beat_idx   = 0;
        end else if (beats_left == 0 && arvalid === 1'b1) begin
          if (!hold_valid) begin
            hold_addr  = araddr;
            hold_len   = arlen;
            hold_valid = 1'b1;
          end
          if (araddr !== hold_addr || arlen !== hold_len) ar_hold_bad++;
          if (stall_cnt < ar_stall) begin
            stall_cnt++;
            ar_held_cycles++;
          end else begin
            arready    = 1'b1;
            stall_cnt  = 0;
            hold_valid = 1'b0;
            ar_addr_log.push_back(araddr);
            ar_len_log.push_back(arlen);
            ar_hs_before.push_back(r_hs_total);
            beat_addr  = araddr;
            burst_len  = int'(arlen) + 1;
          end
        end
        if (beats_left > 0) begin
          rvalid = 1'b1;
          rdata  = pattern(beat_addr);
          rresp  = (beat_idx == err_resp_beat) ? 2'b10 : 2'b00;
          rlast  = (early_last_beat >= 0) ? (beat_idx == early_last_beat) : (beats_left == 1);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
          rresp  = 2'b00;
        end
        rready_prev = rready;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_logs();
    ar_addr_log.delete();
    ar_len_log.delete();
    ar_hs_before.delete();
    beats_seen     = 0;
    ar_held_cycles = 0;
    ar_hold_bad    = 0;
  endtask

  task automatic do_request(input logic [AW-1:0] a, input logic [7:0] l, input bit expect_data);
    logic [AW-1:0] base;
    @(negedge clk);
    read_addr = a;
    read_len  = l;
    read_en   = 1'b1;
    if (expect_data) begin
      base = a & ~AW'(15);
      for (int i = 0; i <= int'(l); i++) data_q.push_back(pattern(base + AW'(16 * i)));
    end
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int busy_cycles, output bit timed_out);
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      else if (data_q.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #3 resetn = 1'b0;
    #1;
    checks += 10;
    if (busy !== 1'b0)         begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (data_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
    if (arvalid !== 1'b0)      begin errors++; $display("[TB] FAIL reset_arvalid: got %b expected 0", arvalid); end
    if (rready !== 1'b0)       begin errors++; $display("[TB] FAIL reset_rready: got %b expected 0", rready); end
    if (araddr !== '0)         begin errors++; $display("[TB] FAIL reset_araddr: got %h expected 0", araddr); end
    if (arlen !== 8'd0)        begin errors++; $display("[TB] FAIL reset_arlen: got %h expected 0", arlen); end
    if (data !== '0)           begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", data); end
    if (read_error !== 3'b000) begin errors++; $display("[TB] FAIL reset_error: got %b expected 000", read_error); end
    if (arsize !== 3'd4)       begin errors++; $display("[TB] FAIL reset_arsize: got %0d expected 4", arsize); end
    if (arburst !== 2'b01)     begin errors++; $display("[TB] FAIL reset_arburst: got %b expected 01", arburst); end
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  task automatic test_aligned_single();
    int bc; bit to;
    $display("[TB] aligned single burst");
    clear_logs();
    do_request(39'h1000, 8'd7, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_rise: got %b expected 1", busy); end
    wait_idle(100, bc, to);
    checks += 7;
    if (to)                     begin errors++; $display("[TB] FAIL single_timeout: request never completed"); end
    if (bc != 8)                begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected 8", bc); end
    if (ar_addr_log.size() != 1) begin errors++; $display("[TB] FAIL single_ar_count: got %0d expected 1", ar_addr_log.size()); end
    else begin
      if (ar_addr_log[0] !== 39'h1000) begin errors++; $display("[TB] FAIL single_araddr: got %h expected 1000", ar_addr_log[0]); end
      if (ar_len_log[0] !== 8'd7)      begin errors++; $display("[TB] FAIL single_arlen: got %0d expected 7", ar_len_log[0]); end
    end
    if (beats_seen != 8)        begin errors++; $display("[TB] FAIL single_beats: got %0d expected 8", beats_seen); end
    if (read_error !== 3'b000)  begin errors++; $display("[TB] FAIL single_error: got %b expected 000", read_error); end
  endtask

  task automatic test_4k_split();
    int bc; bit to;
    $display("[TB] 4 KB split");
    clear_logs();
    do_request(39'h0FC0, 8'd7, 1'b1);
    wait_idle(100, bc, to);
    checks += 4;
    if (to)       begin errors++; $display("[TB] FAIL split_timeout: request never completed"); end
    if (bc != 9)  begin errors++; $display("[TB] FAIL split_busy_len: got %0d expected 9", bc); end
    if (beats_seen != 8) begin errors++; $display("[TB] FAIL split_beats: got %0d expected 8", beats_seen); end
    if (ar_addr_log.size() != 2) begin errors++; $display("[TB] FAIL split_ar_count: got %0d expected 2", ar_addr_log.size()); end
    else begin
      checks += 5;
      if (ar_addr_log[0] !== 39'h0FC0) begin errors++; $display("[TB] FAIL split_araddr0: got %h expected fc0", ar_addr_log[0]); end
      if (ar_len_log[0] !== 8'd3)      begin errors++; $display("[TB] FAIL split_arlen0: got %0d expected 3", ar_len_log[0]); end
      if (ar_addr_log[1] !== 39'h1000) begin errors++; $display("[TB] FAIL split_araddr1: got %h expected 1000", ar_addr_log[1]); end
      if (ar_len_log[1] !== 8'd3)      begin errors++; $display("[TB] FAIL split_arlen1: got %0d expected 3", ar_len_log[1]); end
      if (ar_hs_before[1] - ar_hs_before[0] != 4) begin
        errors++; $display("[TB] FAIL split_ar_order: %0d beats before AR#2 expected 4", ar_hs_before[1] - ar_hs_before[0]);
      end
    end
  endtask

  task automatic test_ar_stall();
    int bc; bit to;
    $display("[TB] AR stall with unaligned address");
    clear_logs();
    ar_stall = 5;
    do_request(39'h2008, 8'd0, 1'b1);
    wait_idle(100, bc, to);
    ar_stall = 0;
    checks += 5;
    if (to)                  begin errors++; $display("[TB] FAIL stall_timeout: request never completed"); end
    if (ar_held_cycles != 5) begin errors++; $display("[TB] FAIL stall_held: arvalid held %0d stalled cycles expected 5", ar_held_cycles); end
    if (ar_hold_bad != 0)    begin errors++; $display("[TB] FAIL stall_stable: %0d cycles with changed AR expected 0", ar_hold_bad); end
    if (beats_seen != 1)     begin errors++; $display("[TB] FAIL stall_beats: got %0d expected 1", beats_seen); end
    if (ar_addr_log.size() != 1) begin errors++; $display("[TB] FAIL stall_ar_count: got %0d expected 1", ar_addr_log.size()); end
    else begin
      checks += 2;
      if (ar_addr_log[0] !== 39'h2000) begin errors++; $display("[TB] FAIL stall_araddr: got %h expected 2000", ar_addr_log[0]); end
      if (ar_len_log[0] !== 8'd0)      begin errors++; $display("[TB] FAIL stall_arlen: got %0d expected 0", ar_len_log[0]); end
    end
  endtask

  task automatic test_split_cases();
    int bc; bit to;
    logic [AW-1:0] exp_a [4];
    logic [7:0]    exp_l [4];
    $display("[TB] maximal mid-page request and address wrap");
    exp_a[0] = 39'h0800;         exp_l[0] = 8'd127;
    exp_a[1] = 39'h1000;         exp_l[1] = 8'd127;
    exp_a[2] = 39'h7F_FFFF_FF00; exp_l[2] = 8'd15;
    exp_a[3] = 39'h0;            exp_l[3] = 8'd15;
    for (int t = 0; t < 2; t++) begin
      clear_logs();
      if (t == 0) do_request(39'h0800, 8'd255, 1'b1);
      else        do_request(39'h7F_FFFF_FF00, 8'd31, 1'b1);
      wait_idle(700, bc, to);
      checks += 3;
      if (to) begin errors++; $display("[TB] FAIL case%0d_timeout: request never completed", t); end
      if (beats_seen != ((t == 0) ? 256 : 32)) begin
        errors++; $display("[TB] FAIL case%0d_beats: got %0d expected %0d", t, beats_seen, (t == 0) ? 256 : 32);
      end
      if (ar_addr_log.size() != 2) begin errors++; $display("[TB] FAIL case%0d_ar_count: got %0d expected 2", t, ar_addr_log.size()); end
      else begin
        for (int k = 0; k < 2; k++) begin
          checks += 2;
          if (ar_addr_log[k] !== exp_a[2*t+k]) begin
            errors++; $display("[TB] FAIL case%0d_araddr%0d: got %h expected %h", t, k, ar_addr_log[k], exp_a[2*t+k]);
          end
          if (ar_len_log[k] !== exp_l[2*t+k]) begin
            errors++; $display("[TB] FAIL case%0d_arlen%0d: got %0d expected %0d", t, k, ar_len_log[k], exp_l[2*t+k]);
          end
        end
      end
    end
  endtask

  task automatic test_rresp_error();
    int bc; bit to;
    $display("[TB] RRESP error and clear");
    clear_logs();
    err_resp_beat = 2;
    do_request(39'h4000, 8'd3, 1'b1);
    wait_idle(100, bc, to);
    err_resp_beat = -1;
    checks += 3;
    if (to)                    begin errors++; $display("[TB] FAIL rresp_timeout: request never completed"); end
    if (beats_seen != 4)       begin errors++; $display("[TB] FAIL rresp_beats: got %0d expected 4", beats_seen); end
    if (read_error !== 3'b001) begin errors++; $display("[TB] FAIL rresp_flag: got %b expected 001", read_error); end
    repeat (3) @(negedge clk);
    checks++;
    if (read_error !== 3'b001) begin errors++; $display("[TB] FAIL rresp_sticky: got %b expected 001", read_error); end
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    checks++;
    if (read_error !== 3'b000) begin errors++; $display("[TB] FAIL rresp_clear: got %b expected 000", read_error); end
  endtask

  task automatic test_early_rlast();
    int bc; bit to;
    $display("[TB] early RLAST");
    clear_logs();
    early_last_beat = 1;
    do_request(39'h4100, 8'd3, 1'b1);
    wait_idle(100, bc, to);
    early_last_beat = -1;
    checks += 3;
    if (to)                    begin errors++; $display("[TB] FAIL rlast_timeout: request never completed"); end
    if (beats_seen != 4)       begin errors++; $display("[TB] FAIL rlast_beats: got %0d expected 4", beats_seen); end
    if (read_error !== 3'b010) begin errors++; $display("[TB] FAIL rlast_flag: got %b expected 010", read_error); end
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
  endtask

  task automatic test_request_while_busy();
    int bc; bit to;
    $display("[TB] request while busy");
    clear_logs();
    do_request(39'h3000, 8'd7, 1'b1);
    repeat (3) @(negedge clk);
    do_request(39'h5000, 8'd3, 1'b0);
    checks++;
    if (read_error !== 3'b100) begin errors++; $display("[TB] FAIL busy_drop_flag: got %b expected 100", read_error); end
    read_en     = 1'b1;
    error_clear = 1'b1;
    @(negedge clk);
    read_en     = 1'b0;
    error_clear = 1'b0;
    checks++;
    if (read_error !== 3'b100) begin errors++; $display("[TB] FAIL busy_set_wins: got %b expected 100", read_error); end
    wait_idle(100, bc, to);
    checks += 3;
    if (to)              begin errors++; $display("[TB] FAIL busy_timeout: request never completed"); end
    if (beats_seen != 8) begin errors++; $display("[TB] FAIL busy_beats: got %0d expected 8", beats_seen); end
    if (ar_addr_log.size() != 1) begin errors++; $display("[TB] FAIL busy_ar_count: got %0d expected 1", ar_addr_log.size()); end
    else begin
      checks++;
      if (ar_addr_log[0] !== 39'h3000) begin errors++; $display("[TB] FAIL busy_araddr: got %h expected 3000", ar_addr_log[0]); end
    end
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    checks++;
    if (read_error !== 3'b000) begin errors++; $display("[TB] FAIL busy_clear: got %b expected 000", read_error); end
  endtask

  task automatic test_reset_mid();
    int bc; bit to; int start; bit reached;
    $display("[TB] reset during data phase");
    clear_logs();
    start   = r_hs_total;
    reached = 1'b0;
    do_request(39'h6000, 8'd7, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (r_hs_total - start >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin errors++; $display("[TB] FAIL midrst_timeout: 3 beats never returned"); end
    #2 resetn = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", data_valid); end
    if (arvalid !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_arvalid: got %b expected 0", arvalid); end
    if (rready !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_rready: got %b expected 0", rready); end
    repeat (2) @(negedge clk);
    data_q.delete();
    #2 resetn = 1'b1;
    clear_logs();
    do_request(39'h7000, 8'd1, 1'b1);
    wait_idle(100, bc, to);
    checks += 3;
    if (to)                    begin errors++; $display("[TB] FAIL midrst_new_timeout: request never completed"); end
    if (beats_seen != 2)       begin errors++; $display("[TB] FAIL midrst_new_beats: got %0d expected 2", beats_seen); end
    if (read_error !== 3'b000) begin errors++; $display("[TB] FAIL midrst_new_error: got %b expected 000", read_error); end
    checks++;
    if (ar_addr_log.size() != 1) begin errors++; $display("[TB] FAIL midrst_ar_count: got %0d expected 1", ar_addr_log.size()); end
    else begin
      checks += 2;
      if (ar_addr_log[0] !== 39'h7000) begin errors++; $display("[TB] FAIL midrst_araddr: got %h expected 7000", ar_addr_log[0]); end
      if (ar_len_log[0] !== 8'd1)      begin errors++; $display("[TB] FAIL midrst_arlen: got %0d expected 1", ar_len_log[0]); end
    end
  endtask

  initial begin : main
    resetn      = 1'b1;
    read_addr   = '0;
    read_len    = '0;
    read_en     = 1'b0;
    error_clear = 1'b0;
    test_reset();
    test_aligned_single();
    test_4k_split();
    test_ar_stall();
    test_split_cases();
    test_rresp_error();
    test_early_rlast();
    test_request_while_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
